// File: rtl/if_fetch_stage.sv
// Instruction-fetch front end: owns the PC, issues one sram-style fetch at a time,
// and presents the fetched instruction to the IF/ID boundary.
module if_fetch_stage #(
  parameter logic [31:0] RESET_PC = 32'hbfc00000,
  parameter int          STALL_W  = 8
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [STALL_W-1:0] stall,
  input  logic               flush,
  input  logic [31:0]        new_pc,
  input  logic               br_e,
  input  logic [31:0]        br_addr,
  output logic               inst_sram_req,
  output logic [31:0]        inst_sram_addr,
  input  logic               inst_sram_addr_ok,
  input  logic               inst_sram_data_ok,
  input  logic [31:0]        inst_sram_rdata,
  output logic               if_valid,
  output logic [31:0]        if_pc,
  output logic [31:0]        if_inst,
  output logic [31:0]        if_excepttype,
  output logic               stallreq_from_icache
);

  typedef enum logic [2:0] {IDLE, REQ, DATA, CANCEL, DONE} state_t;

  state_t      state, state_next;
  logic [31:0] pc, pc_next;
  logic [31:0] inst_buf, inst_buf_next;
  logic [31:0] exc_buf, exc_buf_next;
  logic [31:0] br_tgt, br_tgt_next;
  logic        br_pend, br_pend_next;
  logic        req, valid;
  logic        hold;
  logic        misaligned;
  logic [31:0] seq_pc;
  logic        unused_stall;

  // A lone stall[0] is treated the same as stall[1].
  assign hold         = stall[1] | stall[0];
  assign unused_stall = ^stall;
  assign misaligned   = (pc[1:0] != 2'b00);
  assign seq_pc       = br_e ? br_addr : (br_pend ? br_tgt : pc + 32'd4);

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      pc       <= RESET_PC;
      inst_buf <= 32'd0;
      exc_buf  <= 32'd0;
      br_pend  <= 1'b0;
      br_tgt   <= 32'd0;
    end else begin
      state    <= state_next;
      pc       <= pc_next;
      inst_buf <= inst_buf_next;
      exc_buf  <= exc_buf_next;
      br_pend  <= br_pend_next;
      br_tgt   <= br_tgt_next;
    end
  end

  always_comb begin
    state_next    = state;
    pc_next       = pc;
    inst_buf_next = inst_buf;
    exc_buf_next  = exc_buf;
    br_pend_next  = br_pend;
    br_tgt_next   = br_tgt;
    req           = 1'b0;
    valid         = 1'b0;

    if (flush) begin
      // Redirect wins; an in-flight access must still be drained in CANCEL.
      pc_next      = new_pc;
      br_pend_next = 1'b0;
      case (state)
        REQ:     state_next = inst_sram_addr_ok ? CANCEL : REQ;
        DATA:    state_next = inst_sram_data_ok ? REQ : CANCEL;
        CANCEL:  state_next = inst_sram_data_ok ? REQ : CANCEL;
        default: state_next = REQ;
      endcase
    end else begin
      case (state)
        IDLE: state_next = REQ;
        REQ: begin
          if (misaligned) begin
            state_next    = DONE;
            exc_buf_next  = 32'h4;
            inst_buf_next = 32'd0;
          end else begin
            req = 1'b1;
            if (inst_sram_addr_ok) state_next = DATA;
          end
        end
        DATA: begin
          if (inst_sram_data_ok) begin
            inst_buf_next = inst_sram_rdata;
            exc_buf_next  = 32'd0;
            state_next    = DONE;
          end
        end
        CANCEL: begin
          if (inst_sram_data_ok) state_next = REQ;
        end
        DONE: begin
          valid = 1'b1;
          if (!hold) begin
            pc_next      = seq_pc;
            br_pend_next = 1'b0;
            state_next   = REQ;
          end
        end
        default: state_next = IDLE;
      endcase

      // Branch resolved while its delay slot is still in IF: remember the target.
      if (br_e && !hold && state != DONE) begin
        br_pend_next = 1'b1;
        br_tgt_next  = br_addr;
      end
    end
  end

  assign inst_sram_req        = req & ~rst;
  assign inst_sram_addr       = pc;
  assign if_pc                = pc;
  assign if_valid             = valid & ~rst;
  assign if_inst              = inst_buf;
  assign if_excepttype        = exc_buf;
  assign stallreq_from_icache = (state != DONE) & ~rst;

endmodule

// File: tb/tb_if_fetch_stage.sv
// Directed bench for if_fetch_stage: scripted slave responses, one task per scenario.
module tb_if_fetch_stage;

  logic        clk = 1'b0;
  logic        rst;
  logic [7:0]  stall;
  logic        flush;
  logic [31:0] new_pc;
  logic        br_e;
  logic [31:0] br_addr;
  logic        inst_sram_req;
  logic [31:0] inst_sram_addr;
  logic        inst_sram_addr_ok;
  logic        inst_sram_data_ok;
  logic [31:0] inst_sram_rdata;
  logic        if_valid;
  logic [31:0] if_pc;
  logic [31:0] if_inst;
  logic [31:0] if_excepttype;
  logic        stallreq_from_icache;

  int n_checks = 0;
  int n_fail   = 0;

  if_fetch_stage #(.RESET_PC(32'hbfc00000), .STALL_W(8)) dut (
    .clk(clk), .rst(rst), .stall(stall), .flush(flush), .new_pc(new_pc),
    .br_e(br_e), .br_addr(br_addr),
    .inst_sram_req(inst_sram_req), .inst_sram_addr(inst_sram_addr),
    .inst_sram_addr_ok(inst_sram_addr_ok), .inst_sram_data_ok(inst_sram_data_ok),
    .inst_sram_rdata(inst_sram_rdata),
    .if_valid(if_valid), .if_pc(if_pc), .if_inst(if_inst),
    .if_excepttype(if_excepttype), .stallreq_from_icache(stallreq_from_icache)
  );

  always #5 clk = ~clk;

  // Inputs change 2 time units after the edge; checks run 1 unit later.
  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic test_reset();
    rst = 1'b1; stall = 8'h00; flush = 1'b0; new_pc = 32'h0; br_e = 1'b0; br_addr = 32'h0;
    inst_sram_addr_ok = 1'b0; inst_sram_data_ok = 1'b0; inst_sram_rdata = 32'h0;
    tick(); tick(); #1;
    n_checks++; if (inst_sram_req !== 1'b0) begin n_fail++; $display("FAIL reset_req got=%b exp=0", inst_sram_req); end
    n_checks++; if (if_valid !== 1'b0) begin n_fail++; $display("FAIL reset_valid got=%b exp=0", if_valid); end
    n_checks++; if (stallreq_from_icache !== 1'b0) begin n_fail++; $display("FAIL reset_stallreq got=%b exp=0", stallreq_from_icache); end
    n_checks++; if (if_inst !== 32'h0 || if_excepttype !== 32'h0) begin n_fail++; $display("FAIL reset_bufs inst=%h exc=%h exp=0/0", if_inst, if_excepttype); end
    n_checks++; if (inst_sram_addr !== 32'hbfc00000) begin n_fail++; $display("FAIL reset_pc got=%h exp=bfc00000", inst_sram_addr); end
    $display("reset: req=%b valid=%b addr=%h", inst_sram_req, if_valid, inst_sram_addr);
  endtask

  task automatic test_reset_fetch();
    rst = 1'b0; #1;
    n_checks++; if (inst_sram_req !== 1'b0 || stallreq_from_icache !== 1'b1) begin n_fail++; $display("FAIL idle_cycle req=%b stallreq=%b exp=0/1", inst_sram_req, stallreq_from_icache); end
    tick(); inst_sram_addr_ok = 1'b1; #1;
    n_checks++; if (inst_sram_req !== 1'b1 || inst_sram_addr !== 32'hbfc00000) begin n_fail++; $display("FAIL first_req req=%b addr=%h exp=1/bfc00000", inst_sram_req, inst_sram_addr); end
    n_checks++; if (stallreq_from_icache !== 1'b1) begin n_fail++; $display("FAIL stallreq_req got=%b exp=1", stallreq_from_icache); end
    tick(); inst_sram_addr_ok = 1'b0; inst_sram_data_ok = 1'b1; inst_sram_rdata = 32'h24010001; #1;
    n_checks++; if (inst_sram_req !== 1'b0 || stallreq_from_icache !== 1'b1 || if_valid !== 1'b0) begin n_fail++; $display("FAIL data_wait req=%b stallreq=%b valid=%b exp=0/1/0", inst_sram_req, stallreq_from_icache, if_valid); end
    tick(); inst_sram_data_ok = 1'b0; #1;
    n_checks++; if (if_valid !== 1'b1 || if_inst !== 32'h24010001 || if_pc !== 32'hbfc00000) begin n_fail++; $display("FAIL done_first valid=%b inst=%h pc=%h exp=1/24010001/bfc00000", if_valid, if_inst, if_pc); end
    n_checks++; if (stallreq_from_icache !== 1'b0 || if_excepttype !== 32'h0) begin n_fail++; $display("FAIL done_flags stallreq=%b exc=%h exp=0/0", stallreq_from_icache, if_excepttype); end
    tick(); #1;
    n_checks++; if (inst_sram_req !== 1'b1 || inst_sram_addr !== 32'hbfc00004) begin n_fail++; $display("FAIL second_req req=%b addr=%h exp=1/bfc00004", inst_sram_req, inst_sram_addr); end
    $display("reset_fetch: inst=%h next_addr=%h", if_inst, inst_sram_addr);
  endtask

  task automatic test_slow_slave();
    for (int i = 0; i < 3; i++) begin
      tick(); #1;
      n_checks++; if (inst_sram_req !== 1'b1 || inst_sram_addr !== 32'hbfc00004) begin n_fail++; $display("FAIL slow_hold[%0d] req=%b addr=%h exp=1/bfc00004", i, inst_sram_req, inst_sram_addr); end
    end
    inst_sram_addr_ok = 1'b1;
    tick(); inst_sram_addr_ok = 1'b0; inst_sram_data_ok = 1'b1; inst_sram_rdata = 32'h8c020010;
    tick(); inst_sram_data_ok = 1'b0; stall = 8'h7f; #1;
    n_checks++; if (if_valid !== 1'b1 || if_inst !== 32'h8c020010) begin n_fail++; $display("FAIL slow_capture valid=%b inst=%h exp=1/8c020010", if_valid, if_inst); end
    $display("slow_slave: inst=%h pc=%h", if_inst, if_pc);
  endtask

  task automatic test_stall_hold();
    for (int i = 0; i < 4; i++) begin
      // A stray data_ok while holding must not overwrite the buffered instruction.
      inst_sram_data_ok = (i == 1); inst_sram_rdata = 32'hdeadbeef;
      tick(); #1;
      n_checks++; if (if_valid !== 1'b1 || if_inst !== 32'h8c020010 || if_pc !== 32'hbfc00004 || inst_sram_req !== 1'b0) begin
        n_fail++; $display("FAIL stall_hold[%0d] valid=%b inst=%h pc=%h req=%b exp=1/8c020010/bfc00004/0", i, if_valid, if_inst, if_pc, inst_sram_req); end
    end
    inst_sram_data_ok = 1'b0; stall = 8'h00;
    tick(); #1;
    n_checks++; if (inst_sram_req !== 1'b1 || inst_sram_addr !== 32'hbfc00008) begin n_fail++; $display("FAIL stall_release req=%b addr=%h exp=1/bfc00008", inst_sram_req, inst_sram_addr); end
    $display("stall_hold: released, next_addr=%h", inst_sram_addr);
  endtask

  task automatic test_branch_delay_slot();
    inst_sram_addr_ok = 1'b1;
    tick(); inst_sram_addr_ok = 1'b0; br_e = 1'b1; br_addr = 32'hbfc00100;
    tick(); br_e = 1'b0; br_addr = 32'h0; inst_sram_data_ok = 1'b1; inst_sram_rdata = 32'h00000021;
    tick(); inst_sram_data_ok = 1'b0; #1;
    n_checks++; if (if_valid !== 1'b1 || if_inst !== 32'h00000021 || if_pc !== 32'hbfc00008) begin n_fail++; $display("FAIL delay_slot valid=%b inst=%h pc=%h exp=1/00000021/bfc00008", if_valid, if_inst, if_pc); end
    tick(); #1;
    n_checks++; if (inst_sram_req !== 1'b1 || inst_sram_addr !== 32'hbfc00100) begin n_fail++; $display("FAIL branch_target req=%b addr=%h exp=1/bfc00100", inst_sram_req, inst_sram_addr); end
    $display("branch: delay_slot=%h target=%h", if_inst, inst_sram_addr);
  endtask

  task automatic test_flush_data();
    inst_sram_addr_ok = 1'b1;
    tick(); inst_sram_addr_ok = 1'b0; flush = 1'b1; new_pc = 32'hbfc00380; #1;
    n_checks++; if (if_valid !== 1'b0 || stallreq_from_icache !== 1'b1) begin n_fail++; $display("FAIL flush_cycle valid=%b stallreq=%b exp=0/1", if_valid, stallreq_from_icache); end
    tick(); flush = 1'b0; new_pc = 32'h0; #1;
    n_checks++; if (inst_sram_req !== 1'b0 || inst_sram_addr !== 32'hbfc00380) begin n_fail++; $display("FAIL cancel_wait req=%b addr=%h exp=0/bfc00380", inst_sram_req, inst_sram_addr); end
    tick(); inst_sram_data_ok = 1'b1; inst_sram_rdata = 32'hbadbad00; #1;
    n_checks++; if (if_valid !== 1'b0) begin n_fail++; $display("FAIL stale_data valid=%b exp=0", if_valid); end
    tick(); inst_sram_data_ok = 1'b0; #1;
    n_checks++; if (inst_sram_req !== 1'b1 || inst_sram_addr !== 32'hbfc00380 || if_valid !== 1'b0) begin n_fail++; $display("FAIL refetch req=%b addr=%h valid=%b exp=1/bfc00380/0", inst_sram_req, inst_sram_addr, if_valid); end
    inst_sram_addr_ok = 1'b1;
    tick(); inst_sram_addr_ok = 1'b0; inst_sram_data_ok = 1'b1; inst_sram_rdata = 32'h11112222;
    tick(); inst_sram_data_ok = 1'b0; #1;
    n_checks++; if (if_valid !== 1'b1 || if_inst !== 32'h11112222 || if_pc !== 32'hbfc00380) begin n_fail++; $display("FAIL flush_fetch valid=%b inst=%h pc=%h exp=1/11112222/bfc00380", if_valid, if_inst, if_pc); end
    $display("flush_data: refetched inst=%h at pc=%h", if_inst, if_pc);
  endtask

  task automatic test_misaligned();
    flush = 1'b1; new_pc = 32'hbfc00382; #1;
    n_checks++; if (if_valid !== 1'b0) begin n_fail++; $display("FAIL flush_done valid=%b exp=0", if_valid); end
    tick(); flush = 1'b0; new_pc = 32'h0; #1;
    n_checks++; if (inst_sram_req !== 1'b0 || stallreq_from_icache !== 1'b1) begin n_fail++; $display("FAIL misaligned_noreq req=%b stallreq=%b exp=0/1", inst_sram_req, stallreq_from_icache); end
    tick(); #1;
    n_checks++; if (if_valid !== 1'b1 || if_excepttype !== 32'h4 || if_pc !== 32'hbfc00382 || if_inst !== 32'h0 || inst_sram_req !== 1'b0) begin
      n_fail++; $display("FAIL misaligned_done valid=%b exc=%h pc=%h inst=%h req=%b exp=1/4/bfc00382/0/0", if_valid, if_excepttype, if_pc, if_inst, inst_sram_req); end
    $display("misaligned: exc=%h pc=%h", if_excepttype, if_pc);
  endtask

  task automatic test_reset_mid();
    rst = 1'b1; #1;
    n_checks++; if (if_valid !== 1'b0 || stallreq_from_icache !== 1'b0 || inst_sram_req !== 1'b0) begin n_fail++; $display("FAIL rst_outputs valid=%b stallreq=%b req=%b exp=0/0/0", if_valid, stallreq_from_icache, inst_sram_req); end
    tick(); rst = 1'b0; inst_sram_data_ok = 1'b1; inst_sram_rdata = 32'h55555555; #1;
    n_checks++; if (if_pc !== 32'hbfc00000 || if_excepttype !== 32'h0 || if_inst !== 32'h0) begin n_fail++; $display("FAIL rst_state pc=%h exc=%h inst=%h exp=bfc00000/0/0", if_pc, if_excepttype, if_inst); end
    tick(); inst_sram_data_ok = 1'b0; #1;
    n_checks++; if (inst_sram_req !== 1'b1 || inst_sram_addr !== 32'hbfc00000 || if_valid !== 1'b0) begin n_fail++; $display("FAIL rst_refetch req=%b addr=%h valid=%b exp=1/bfc00000/0", inst_sram_req, inst_sram_addr, if_valid); end
    $display("reset_mid: refetch addr=%h", inst_sram_addr);
  endtask

  initial begin
    test_reset();
    test_reset_fetch();
    test_slow_slave();
    test_stall_hold();
    test_branch_delay_slot();
    test_flush_data();
    test_misaligned();
    test_reset_mid();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
